// File: rtl/ones_word_gen.sv
// Serial thermometer-code generator: shifts N ones into a word, one per clock.
// Controller/datapath split with start/rdy handshake and a one-cycle done pulse.
module ones_word_gen_dp #(
    parameter int R1_SIZE = 8,
    parameter int R2_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_shift_en,
    input  logic               i_dec_en,
    input  logic [R2_SIZE-1:0] i_count,
    output logic [R1_SIZE-1:0] o_data,
    output logic               o_zero
);
    localparam logic [R2_SIZE-1:0] MAXC = R2_SIZE'(R1_SIZE);

    logic [R1_SIZE-1:0] r_word;
    logic [R2_SIZE-1:0] r_cnt;
    logic [R2_SIZE-1:0] w_clamp;

    // Counts above the word width saturate at a full word of ones
    assign w_clamp = (i_count > MAXC) ? MAXC : i_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load)
                r_word <= '0;
            else if (i_shift_en)
                r_word <= {r_word[R1_SIZE-2:0], 1'b1};

            if (i_load)
                r_cnt <= w_clamp;
            else if (i_dec_en)
                r_cnt <= r_cnt - R2_SIZE'(1);
        end
    end

    assign o_data = r_word;
    assign o_zero = (r_cnt == '0);
endmodule

module ones_word_gen_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_zero,
    output logic o_rdy,
    output logic o_done,
    output logic o_load,
    output logic o_shift_en,
    output logic o_dec_en
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    logic   r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (i_zero) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_rdy      = (r_state == S_IDLE);
    assign o_done     = r_done;
    assign o_load     = o_rdy & i_start;
    assign o_shift_en = (r_state == S_RUN) & ~i_zero;
    assign o_dec_en   = o_shift_en;
endmodule

module ones_word_gen #(
    parameter int R1_SIZE = 8,
    parameter int R2_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [R2_SIZE-1:0] count,
    output logic [R1_SIZE-1:0] data,
    output logic               rdy,
    output logic               done
);
    logic w_load;
    logic w_shift_en;
    logic w_dec_en;
    logic w_zero;

    ones_word_gen_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_zero     (w_zero),
        .o_rdy      (rdy),
        .o_done     (done),
        .o_load     (w_load),
        .o_shift_en (w_shift_en),
        .o_dec_en   (w_dec_en)
    );

    ones_word_gen_dp #(
        .R1_SIZE (R1_SIZE),
        .R2_SIZE (R2_SIZE)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_dec_en   (w_dec_en),
        .i_count    (count),
        .o_data     (data),
        .o_zero     (w_zero)
    );
endmodule

// File: tb/tb_ones_word_gen.sv
// Bench for ones_word_gen: vector table, corner sequences, random vs model.
module tb_ones_word_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] data;
    logic       rdy;
    logic       done;

    int errors = 0;
    int checks = 0;

    ones_word_gen #(.R1_SIZE(8), .R2_SIZE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .count (count),
        .data  (data),
        .rdy   (rdy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int exp_busy;
        int exp_data;
    } vec_t;

    vec_t vecs[8];

    // Reference: cycles since acceptance determine the word
    bit m_busy;
    int m_j;
    int m_n;
    int m_word;
    bit m_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit r, input bit s, input int c);
        if (r) begin
            m_busy = 0;
            m_word = 0;
            m_done = 0;
        end else if (!m_busy && s) begin
            m_busy = 1;
            m_n    = (c > 8) ? 8 : c;
            m_j    = 0;
            m_done = 0;
        end else if (m_busy) begin
            m_j++;
            m_done = 0;
            if (m_j == m_n + 1) begin
                m_busy = 0;
                m_done = 1;
                m_word = (1 << m_n) - 1;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic run_txn(input int cnt, input int eb, input int ed, input string tag);
        int busy;
        busy = 0;
        start = 1'b1;
        count = 4'(cnt);
        tick();
        start = 1'b0;
        count = 4'($urandom_range(0, 15));
        while (!rdy && busy < 40) begin
            busy++;
            tick();
        end
        chk({tag, "_busy"}, busy, eb);
        chk({tag, "_data"}, int'(data), ed);
        chk({tag, "_done"}, int'(done), 1);
        tick();
        chk({tag, "_done_clr"}, int'(done), 0);
        chk({tag, "_hold"}, int'(data), ed);
    endtask

    initial begin
        int busy;
        int ndone;
        int last;
        bit r_v;
        bit s_v;
        int c_v;
        int seq[5];

        vecs[0] = '{0, 1, 8'h00};
        vecs[1] = '{3, 4, 8'h07};
        vecs[2] = '{8, 9, 8'hFF};
        vecs[3] = '{15, 9, 8'hFF};
        vecs[4] = '{1, 2, 8'h01};
        vecs[5] = '{5, 6, 8'h1F};
        vecs[6] = '{9, 9, 8'hFF};
        vecs[7] = '{7, 8, 8'h7F};

        // Reset held with start asserted
        rst = 1'b1;
        start = 1'b1;
        count = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_data", int'(data), 0);
            chk("rst_rdy", int'(rdy), 1);
            chk("rst_done", int'(done), 0);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("rel_data", int'(data), 0);
        chk("rel_rdy", int'(rdy), 1);
        chk("rel_done", int'(done), 0);

        // Basic sequence, count=3
        seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h07};
        start = 1'b1;
        count = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("basic_seq", int'(data), seq[i]);
            chk("basic_rdy", int'(rdy), 0);
            chk("basic_nodone", int'(done), 0);
            tick();
        end
        chk("basic_fin", int'(data), seq[4]);
        chk("basic_rdy1", int'(rdy), 1);
        chk("basic_done", int'(done), 1);
        tick();

        foreach (vecs[k])
            run_txn(vecs[k].cnt, vecs[k].exp_busy, vecs[k].exp_data, "vec");

        // Start toggled and count changed while busy
        start = 1'b1;
        count = 4'd5;
        tick();
        busy = 0;
        while (!rdy && busy < 40) begin
            busy++;
            start = 1'($urandom_range(0, 1));
            count = 4'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0;
        chk("abuse_busy", busy, 6);
        chk("abuse_data", int'(data), 8'h1F);
        chk("abuse_done", int'(done), 1);
        tick();

        // Start held high: done and the next load coincide
        start = 1'b1;
        count = 4'd2;
        ndone = 0;
        last = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (done) begin
                ndone++;
                chk("b2b_gap", i - last, 4);
                chk("b2b_data", int'(data), 8'h03);
                chk("b2b_rdy", int'(rdy), 1);
                last = i;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 6);
        tick();

        // Reset during the third busy cycle
        start = 1'b1;
        count = 4'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_data", int'(data), 0);
        chk("mid_rdy", int'(rdy), 1);
        chk("mid_done", int'(done), 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done)
                ndone++;
        end
        chk("mid_nodone", ndone, 0);
        run_txn(1, 2, 8'h01, "post_rst");

        // Randomized traffic against the model
        rst = 1'b1;
        start = 1'b0;
        tick();
        model_step(1'b1, 1'b0, 0);
        for (int i = 0; i < 500; i++) begin
            r_v = ($urandom_range(0, 40) == 0);
            s_v = ($urandom_range(0, 2) != 0);
            c_v = $urandom_range(0, 15);
            rst = r_v;
            start = s_v;
            count = 4'(c_v);
            tick();
            model_step(r_v, s_v, c_v);
            chk("rnd_data", int'(data), m_busy ? ((1 << m_j) - 1) : m_word);
            chk("rnd_rdy", int'(rdy), int'(!m_busy));
            chk("rnd_done", int'(done), int'(m_done));
        end
        rst = 1'b0;
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
